// File: rtl/aes_pkg.sv
// Shared definitions for the AES round sequencer: FSM encoding, counter width
// and the rule tying the round count to the key length.
package aes_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } seq_state_e;

  function automatic int nr_from_nk(input int nk);
    return nk + 6;
  endfunction

  function automatic bit nk_supported(input int nk);
    return (nk == 4) || (nk == 6) || (nk == 8);
  endfunction

endpackage

// File: rtl/aes_round_sequencer.sv
// Steps one 128-bit block through the AES rounds using an external round
// datapath and key-schedule store, one round per clock.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     plaintext,
  output logic [CNT_W-1:0] rk_idx,
  input  logic [127:0]     rk_data,
  output logic [127:0]     rnd_state,
  output logic [127:0]     rnd_key,
  output logic             rnd_final,
  input  logic [127:0]     rnd_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     ciphertext
);

  if (!nk_supported(Nk) || (Nr != nr_from_nk(Nk))) begin : g_bad_cfg
    $error("aes_round_sequencer: unsupported Nk=%0d / Nr=%0d", Nk, Nr);
  end

  localparam logic [CNT_W-1:0] NR_IDX   = CNT_W'(Nr);
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(Nr - 1);

  seq_state_e       r_fsm;
  seq_state_e       w_fsm_nxt;
  logic [127:0]     r_blk;
  logic [127:0]     w_blk_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_rnd_final;
  logic [CNT_W-1:0] w_rk_idx;

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_blk_nxt   = r_blk;
    w_cnt_nxt   = r_cnt;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_rnd_final = 1'b0;
    w_rk_idx    = '0;

    case (r_fsm)
      ST_IDLE: begin
        w_in_ready = 1'b1;
      end
      ST_INIT: begin
        w_blk_nxt = r_blk ^ rk_data;
        w_cnt_nxt = CNT_W'(1);
        w_fsm_nxt = ST_ROUND;
      end
      ST_ROUND: begin
        w_rk_idx  = r_cnt;
        w_blk_nxt = rnd_result;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == LAST_RND) begin
          w_fsm_nxt = ST_FINAL;
        end
      end
      ST_FINAL: begin
        w_rk_idx    = NR_IDX;
        w_rnd_final = 1'b1;
        w_blk_nxt   = rnd_result;
        w_fsm_nxt   = ST_DONE;
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        w_in_ready  = out_ready;
        if (out_ready) begin
          w_fsm_nxt = ST_IDLE;
        end
      end
      default: begin
        w_fsm_nxt = ST_IDLE;
      end
    endcase

    // A block taken while leaving DONE skips IDLE entirely.
    if (in_valid && w_in_ready) begin
      w_blk_nxt = plaintext;
      w_cnt_nxt = '0;
      w_fsm_nxt = ST_INIT;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values computed before this edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= ST_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // NOTE: the block register is reset even though it is pure data, because it
  // drives the ciphertext port, which must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk <= '0;
      r_cnt <= '0;
    end else begin
      r_blk <= w_blk_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign in_ready   = w_in_ready;
  assign rk_idx     = w_rk_idx;
  assign rnd_state  = r_blk;
  assign rnd_key    = rk_data;
  assign rnd_final  = w_rnd_final;
  assign out_valid  = w_out_valid;
  assign ciphertext = r_blk;

endmodule
